fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Parametrised instruction-fetch stage. It is the successor to the flat pc / pcplus4 / pc_branch / pc_multiplexer chain. It owns the PC register and computes branch and jump targets internally. It talks to a multi-cycle instruction memory over a request/grant/response handshake and presents one buffered instruction to decode with valid/ready flow control. Sits between the instruction memory and the decode stage; redirects arrive from decode.

Parameters:
ADDR_W, 32, PC/address width in bits; at least 28; byte addresses, word aligned.
RESET_PC, 0, PC value loaded on reset.
INSTR_W, 32, instruction word width.

Ports:
clk  in  1  clock; all state updates on posedge.
reset  in  1  synchronous, active-high reset.
imem_req  out  1  request valid; address is on imem_addr.
imem_addr  out  ADDR_W  fetch address (equals pc_q).
imem_gnt  in  1  memory accepts the request this cycle.
imem_rvalid  in  1  response data valid; memory holds it until rvalid&&rready.
imem_rready  out  1  fetch can accept the response.
imem_rdata  in  INSTR_W  instruction word.
if_valid  out  1  output buffer holds an instruction.
if_instr  out  INSTR_W  buffered instruction.
if_pc  out  ADDR_W  address of the buffered instruction.
if_pcplus4  out  ADDR_W  if_pc+4.
id_ready  in  1  decode consumes the buffer this cycle when if_valid.
br_taken  in  1  branch redirect request.
br_imm  in  16  branch sign immediate.
br_pcplus4  in  ADDR_W  pcplus4 of the branching instruction.
jmp_taken  in  1  jump redirect request.
jmp_index  in  26  jump instr_index.

Behaviour:
- Reset:
  - pc_q=RESET_PC; state=S_REQ; kill=0; if_valid=0.
  - if_instr, if_pc and req_pc are cleared to 0.
  - imem_req=0 during the reset cycle.
- States:
  - S_REQ: imem_req=1. On imem_gnt: req_pc<=pc_q, pc_q<=pc_q+4, go to S_WAIT.
  - S_WAIT: imem_req=0. Waits for imem_rvalid&&imem_rready. Then: if kill, discard the data and set kill<=0; otherwise load the buffer (if_valid<=1, if_instr<=rdata, if_pc<=req_pc). Either way, go to S_REQ.
- Handshake rules:
  - imem_rready = !if_valid || id_ready.
  - Only one request is outstanding at a time.
  - Best-case throughput is one instruction per 2 cycles with a 1-cycle memory.
- Consume: if_valid&&id_ready with no new load clears if_valid the next cycle. A load and a consume in the same cycle keeps if_valid=1 with the new data.
- Redirect: redirect = br_taken||jmp_taken.
  - Branch target = br_pcplus4 + (sign-extended br_imm << 2).
  - Jump target = {br_pcplus4[ADDR_W-1:28], jmp_index, 2'b00}.
  - Jump has priority when both are asserted.
- On a redirect cycle:
  - pc_q<=target, overriding any +4 update.
  - if_valid<=0 (flush beats a same-cycle load).
  - If in S_WAIT, or in S_REQ with imem_gnt this cycle, kill<=1 and the pending response is discarded.
  - If a response completes in the same S_WAIT cycle as the redirect, it is discarded, kill stays 0, and the next state is S_REQ.
- Arithmetic: all PC adds are modulo 2^ADDR_W; wrap-around is silent.
- Outputs: if_pcplus4 = if_pc+4, combinational.
- Reset mid-operation: returns to reset state in one cycle. An outstanding memory response after reset is not tracked; the bench must not deliver one.

Decomposition:
- mips_pkg holds:
  - fetch_state_t enum {S_REQ, S_WAIT};
  - function sext16;
  - constant PC_INCR=4.
- Sub-module fetch_next_pc (combinational): inputs pc_q, gnt, branch/jump fields; outputs next_pc and redirect. Instantiated once.

Test Plan:
1. Reset then 1-cycle memory returning 32'h20080005 at address 0, id_ready=1 -> imem_addr sequence 0,4,8; first instruction has if_valid=1, if_pc=0, if_pcplus4=4.
2. Decode stall: id_ready=0 for 5 cycles with if_valid=1 -> imem_rready=0, if_instr held, no second request beyond one outstanding; release -> next instruction loads with no loss or duplication.
3. Branch in S_WAIT: br_taken=1, br_pcplus4=32'h10, br_imm=16'hFFFE -> pc_q=32'h08; pending response dropped; next imem_addr=32'h08.
4. Jump: jmp_taken=1, jmp_index=26'h0000040, br_pcplus4=32'hA0000010 -> next imem_addr=32'hA0000100; with br_taken also asserted the jump still wins.
5. Redirect coinciding with rvalid and with gnt -> if_valid=0 next cycle; in the gnt case the stale response is discarded and exactly one fetch goes to the target.
6. Wrap: RESET_PC=32'hFFFFFFFC -> second imem_addr is 0; a reset asserted in S_WAIT returns pc_q to RESET_PC with if_valid=0.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types, constants and helpers for the fetch stage
package mips_pkg;

  typedef enum logic [0:0] {S_REQ, S_WAIT} fetch_state_t;

  localparam int PC_INCR = 4;
  localparam int SEXT_W  = 64;

  // Wide enough for any supported ADDR_W; callers truncate to their width.
  function automatic logic [SEXT_W-1:0] sext16(input logic [15:0] v);
    return {{(SEXT_W-16){v[15]}}, v};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory request/grant/response bundle
interface fetch_unit_if #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
);
  logic               req;
  logic [ADDR_W-1:0]  addr;
  logic               gnt;
  logic               rvalid;
  logic               rready;
  logic [INSTR_W-1:0] rdata;

  modport master (output req, addr, rready, input gnt, rvalid, rdata);
  modport slave  (input req, addr, rready, output gnt, rvalid, rdata);
endinterface

// File: rtl/fetch_next_pc.sv
// rtl/fetch_next_pc.sv - next PC selection: jump, branch, sequential or hold
module fetch_next_pc
  import mips_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] i_pc_q,
  input  logic              i_gnt,
  input  logic              i_br_taken,
  input  logic [15:0]       i_br_imm,
  input  logic [ADDR_W-1:0] i_br_pcplus4,
  input  logic              i_jmp_taken,
  input  logic [25:0]       i_jmp_index,
  output logic [ADDR_W-1:0] o_next_pc,
  output logic              o_redirect
);

  logic [ADDR_W-1:0] w_br_off;
  logic [ADDR_W-1:0] w_br_tgt;
  logic [ADDR_W-1:0] w_jmp_tgt;

  assign w_br_off = ADDR_W'(sext16(i_br_imm)) << 2;
  assign w_br_tgt = i_br_pcplus4 + w_br_off;

  // Jump keeps the region bits above bit 27 of the branching instruction's pcplus4.
  generate
    if (ADDR_W > 28) begin : g_region
      assign w_jmp_tgt = {i_br_pcplus4[ADDR_W-1:28], i_jmp_index, 2'b00};
    end else begin : g_flat
      assign w_jmp_tgt = {i_jmp_index, 2'b00};
    end
  endgenerate

  assign o_redirect = i_br_taken || i_jmp_taken;

  always_comb begin
    o_next_pc = i_pc_q;
    if (i_jmp_taken) begin
      o_next_pc = w_jmp_tgt;
    end else if (i_br_taken) begin
      o_next_pc = w_br_tgt;
    end else if (i_gnt) begin
      o_next_pc = i_pc_q + ADDR_W'(PC_INCR);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with one-entry output buffer
module fetch_unit
  import mips_pkg::*;
#(
  parameter int               ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int               INSTR_W  = 32
) (
  input  logic               clk,
  input  logic               reset,
  fetch_unit_if.master       imem,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [ADDR_W-1:0]  if_pcplus4,
  input  logic               id_ready,
  input  logic               br_taken,
  input  logic [15:0]        br_imm,
  input  logic [ADDR_W-1:0]  br_pcplus4,
  input  logic               jmp_taken,
  input  logic [25:0]        jmp_index
);

  fetch_state_t       r_state;
  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  r_req_pc;
  logic [ADDR_W-1:0]  r_if_pc;
  logic [INSTR_W-1:0] r_instr;
  logic               r_kill;
  logic               r_valid;

  logic               w_gnt_fire;
  logic               w_rready;
  logic               w_resp;
  logic               w_load;
  logic               w_redirect;
  logic [ADDR_W-1:0]  w_next_pc;

  assign w_gnt_fire = (r_state == S_REQ) && imem.gnt;
  assign w_rready   = !r_valid || id_ready;
  assign w_resp     = (r_state == S_WAIT) && imem.rvalid && w_rready;
  // A response is dropped if it was fetched before a redirect or lands on one.
  assign w_load     = w_resp && !r_kill && !w_redirect;

  fetch_next_pc #(.ADDR_W(ADDR_W)) u_next_pc (
    .i_pc_q      (r_pc),
    .i_gnt       (w_gnt_fire),
    .i_br_taken  (br_taken),
    .i_br_imm    (br_imm),
    .i_br_pcplus4(br_pcplus4),
    .i_jmp_taken (jmp_taken),
    .i_jmp_index (jmp_index),
    .o_next_pc   (w_next_pc),
    .o_redirect  (w_redirect)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_REQ;
      r_pc     <= RESET_PC;
      r_req_pc <= '0;
      r_if_pc  <= '0;
      r_instr  <= '0;
      r_kill   <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_pc <= w_next_pc;

      if (r_state == S_REQ) begin
        if (imem.gnt) begin
          r_req_pc <= r_pc;
          r_state  <= S_WAIT;
          r_kill   <= w_redirect;
        end
      end else begin
        if (w_resp) begin
          r_state <= S_REQ;
          r_kill  <= 1'b0;
        end else if (w_redirect) begin
          r_kill <= 1'b1;
        end
      end

      if (w_redirect) begin
        r_valid <= 1'b0;
      end else if (w_load) begin
        r_valid <= 1'b1;
      end else if (id_ready) begin
        r_valid <= 1'b0;
      end

      if (w_load) begin
        r_instr <= imem.rdata;
        r_if_pc <= r_req_pc;
      end
    end
  end

  assign imem.req    = (r_state == S_REQ) && !reset;
  assign imem.addr   = r_pc;
  assign imem.rready = w_rready;

  assign if_valid   = r_valid;
  assign if_instr   = r_instr;
  assign if_pc      = r_if_pc;
  assign if_pcplus4 = r_if_pc + ADDR_W'(PC_INCR);

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed table-driven bench for fetch_unit
module tb_fetch_unit;

  typedef struct {
    logic        rst;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        idr;
    logic        br;
    logic [15:0] imm;
    logic [31:0] bpc;
    logic        jmp;
    logic [25:0] jidx;
    logic        req;
    logic [31:0] addr;
    logic        rready;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        id_ready;
  logic        br_taken;
  logic [15:0] br_imm;
  logic [31:0] br_pcplus4;
  logic        jmp_taken;
  logic [25:0] jmp_index;

  logic        v1_valid, v2_valid;
  logic [31:0] v1_instr, v1_pc, v1_pc4;
  logic [31:0] v2_instr, v2_pc, v2_pc4;

  int n_cmp;
  int n_bad;

  fetch_unit_if #(.ADDR_W(32), .INSTR_W(32)) im1 ();
  fetch_unit_if #(.ADDR_W(32), .INSTR_W(32)) im2 ();

  fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0), .INSTR_W(32)) dut (
    .clk(clk), .reset(reset), .imem(im1),
    .if_valid(v1_valid), .if_instr(v1_instr), .if_pc(v1_pc), .if_pcplus4(v1_pc4),
    .id_ready(id_ready), .br_taken(br_taken), .br_imm(br_imm), .br_pcplus4(br_pcplus4),
    .jmp_taken(jmp_taken), .jmp_index(jmp_index)
  );

  fetch_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC), .INSTR_W(32)) dut_wrap (
    .clk(clk), .reset(reset), .imem(im2),
    .if_valid(v2_valid), .if_instr(v2_instr), .if_pc(v2_pc), .if_pcplus4(v2_pc4),
    .id_ready(id_ready), .br_taken(br_taken), .br_imm(br_imm), .br_pcplus4(br_pcplus4),
    .jmp_taken(jmp_taken), .jmp_index(jmp_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t V(input logic rst, input logic gnt, input logic rvalid,
                             input logic [31:0] rdata, input logic idr,
                             input logic req, input logic [31:0] addr, input logic rready,
                             input logic valid, input logic [31:0] instr, input logic [31:0] pc);
    vec_t v;
    v.rst = rst; v.gnt = gnt; v.rvalid = rvalid; v.rdata = rdata; v.idr = idr;
    v.br = 1'b0; v.imm = '0; v.bpc = '0; v.jmp = 1'b0; v.jidx = '0;
    v.req = req; v.addr = addr; v.rready = rready; v.valid = valid; v.instr = instr; v.pc = pc;
    return v;
  endfunction

  function automatic vec_t R(input vec_t vi, input logic br, input logic [15:0] imm,
                             input logic [31:0] bpc, input logic jmp, input logic [25:0] jidx);
    vec_t v;
    v = vi;
    v.br = br; v.imm = imm; v.bpc = bpc; v.jmp = jmp; v.jidx = jidx;
    return v;
  endfunction

  task automatic chk(input string tag, input int idx, input string name,
                     input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d] %s: got %h expected %h", tag, idx, name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset      = v.rst;
    im1.gnt    = v.gnt;    im2.gnt    = v.gnt;
    im1.rvalid = v.rvalid; im2.rvalid = v.rvalid;
    im1.rdata  = v.rdata;  im2.rdata  = v.rdata;
    id_ready   = v.idr;
    br_taken   = v.br;
    br_imm     = v.imm;
    br_pcplus4 = v.bpc;
    jmp_taken  = v.jmp;
    jmp_index  = v.jidx;
  endtask

  // Inputs change at negedge; outputs are checked 1ns later, well before posedge.
  task automatic step(input vec_t v, input bit sel, input string tag, input int idx);
    @(negedge clk);
    drive(v);
    #1;
    if (!sel) begin
      chk(tag, idx, "req",     {31'd0, im1.req},    {31'd0, v.req});
      chk(tag, idx, "addr",    im1.addr,            v.addr);
      chk(tag, idx, "rready",  {31'd0, im1.rready}, {31'd0, v.rready});
      chk(tag, idx, "valid",   {31'd0, v1_valid},   {31'd0, v.valid});
      chk(tag, idx, "instr",   v1_instr,            v.instr);
      chk(tag, idx, "pc",      v1_pc,               v.pc);
      chk(tag, idx, "pcplus4", v1_pc4,              v.pc + 32'd4);
    end else begin
      chk(tag, idx, "req",     {31'd0, im2.req},    {31'd0, v.req});
      chk(tag, idx, "addr",    im2.addr,            v.addr);
      chk(tag, idx, "rready",  {31'd0, im2.rready}, {31'd0, v.rready});
      chk(tag, idx, "valid",   {31'd0, v2_valid},   {31'd0, v.valid});
      chk(tag, idx, "instr",   v2_instr,            v.instr);
      chk(tag, idx, "pc",      v2_pc,               v.pc);
      chk(tag, idx, "pcplus4", v2_pc4,              v.pc + 32'd4);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(V(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    @(posedge clk);
  endtask

  task automatic run(input vec_t q[$], input bit sel, input string tag);
    for (int i = 0; i < q.size(); i++) begin
      step(q[i], sel, tag, i);
    end
  endtask

  initial begin
    vec_t tbl[$];
    vec_t t3[$];
    vec_t t4[$];
    vec_t t5[$];
    vec_t t6[$];

    n_cmp = 0;
    n_bad = 0;

    // Basic flow, decode stall, and redirect landing on a completing response.
    tbl.push_back(V(1, 0, 0, 0,            1, 0, 32'h0,  1, 0, 32'h0,        32'h0));
    tbl.push_back(V(0, 1, 0, 0,            1, 1, 32'h0,  1, 0, 32'h0,        32'h0));
    tbl.push_back(V(0, 0, 1, 32'h20080005, 1, 0, 32'h4,  1, 0, 32'h0,        32'h0));
    tbl.push_back(V(0, 1, 0, 0,            1, 1, 32'h4,  1, 1, 32'h20080005, 32'h0));
    tbl.push_back(V(0, 0, 1, 32'hA4,       1, 0, 32'h8,  1, 0, 32'h20080005, 32'h0));
    tbl.push_back(V(0, 1, 0, 0,            0, 1, 32'h8,  0, 1, 32'hA4,       32'h4));
    for (int k = 0; k < 4; k++)
      tbl.push_back(V(0, 0, 1, 32'hA8,     0, 0, 32'hC,  0, 1, 32'hA4,       32'h4));
    tbl.push_back(V(0, 0, 1, 32'hA8,       1, 0, 32'hC,  1, 1, 32'hA4,       32'h4));
    tbl.push_back(V(0, 0, 0, 0,            0, 1, 32'hC,  0, 1, 32'hA8,       32'h8));
    tbl.push_back(V(0, 0, 0, 0,            1, 1, 32'hC,  1, 1, 32'hA8,       32'h8));
    tbl.push_back(V(0, 1, 0, 0,            1, 1, 32'hC,  1, 0, 32'hA8,       32'h8));
    tbl.push_back(R(V(0, 0, 1, 32'hAC,     1, 0, 32'h10, 1, 0, 32'hA8,       32'h8),
                    1, 16'h0004, 32'h40, 0, 0));
    tbl.push_back(V(0, 1, 0, 0,            1, 1, 32'h50, 1, 0, 32'hA8,       32'h8));
    tbl.push_back(V(0, 0, 1, 32'hB0,       1, 0, 32'h54, 1, 0, 32'hA8,       32'h8));
    tbl.push_back(V(0, 0, 0, 0,            0, 1, 32'h54, 0, 1, 32'hB0,       32'h50));

    // Branch while waiting: stale response dropped, refetch from 0x08.
    t3.push_back(V(0, 1, 0, 0,           1, 1, 32'h0, 1, 0, 32'h0,    32'h0));
    t3.push_back(R(V(0, 0, 0, 0,         1, 0, 32'h4, 1, 0, 32'h0,    32'h0), 1, 16'hFFFE, 32'h10, 0, 0));
    t3.push_back(V(0, 0, 1, 32'hDEAD,    1, 0, 32'h8, 1, 0, 32'h0,    32'h0));
    t3.push_back(V(0, 1, 0, 0,           1, 1, 32'h8, 1, 0, 32'h0,    32'h0));
    t3.push_back(V(0, 0, 1, 32'h1234,    1, 0, 32'hC, 1, 0, 32'h0,    32'h0));
    t3.push_back(V(0, 0, 0, 0,           0, 1, 32'hC, 0, 1, 32'h1234, 32'h8));

    // Jump keeps the upper region; jump beats a simultaneous branch.
    t4.push_back(R(V(0, 0, 0, 0,        1, 1, 32'h0,        1, 0, 0, 0), 0, 16'h0, 32'hA0000010, 1, 26'h40));
    t4.push_back(V(0, 0, 0, 0,          1, 1, 32'hA0000100, 1, 0, 0, 0));
    t4.push_back(R(V(0, 0, 0, 0,        1, 1, 32'hA0000100, 1, 0, 0, 0), 1, 16'h0010, 32'hA0000010, 1, 26'h80));
    t4.push_back(V(0, 1, 0, 0,          1, 1, 32'hA0000200, 1, 0, 0, 0));
    t4.push_back(V(0, 0, 1, 32'h4321,   1, 0, 32'hA0000204, 1, 0, 0, 0));
    t4.push_back(V(0, 0, 0, 0,          0, 1, 32'hA0000204, 0, 1, 32'h4321, 32'hA0000200));

    // Redirect coinciding with a grant while the buffer is full.
    t5.push_back(V(0, 1, 0, 0,          1, 1, 32'h0,   1, 0, 32'h0,    32'h0));
    t5.push_back(V(0, 0, 1, 32'h7777,   1, 0, 32'h4,   1, 0, 32'h0,    32'h0));
    t5.push_back(R(V(0, 1, 0, 0,        0, 1, 32'h4,   0, 1, 32'h7777, 32'h0), 1, 16'h0008, 32'h100, 0, 0));
    t5.push_back(V(0, 0, 1, 32'hBAD0,   1, 0, 32'h120, 1, 0, 32'h7777, 32'h0));
    t5.push_back(V(0, 1, 0, 0,          1, 1, 32'h120, 1, 0, 32'h7777, 32'h0));
    t5.push_back(V(0, 0, 1, 32'h5555,   1, 0, 32'h124, 1, 0, 32'h7777, 32'h0));
    t5.push_back(V(0, 0, 0, 0,          0, 1, 32'h124, 0, 1, 32'h5555, 32'h120));

    // Wrap from 0xFFFFFFFC and reset asserted while waiting.
    t6.push_back(V(0, 1, 0, 0,          1, 1, 32'hFFFFFFFC, 1, 0, 32'h0,  32'h0));
    t6.push_back(V(0, 0, 1, 32'h99,     1, 0, 32'h0,        1, 0, 32'h0,  32'h0));
    t6.push_back(V(0, 1, 0, 0,          0, 1, 32'h0,        0, 1, 32'h99, 32'hFFFFFFFC));
    t6.push_back(V(1, 0, 0, 0,          0, 0, 32'h4,        0, 1, 32'h99, 32'hFFFFFFFC));
    t6.push_back(V(0, 0, 0, 0,          0, 1, 32'hFFFFFFFC, 1, 0, 32'h0,  32'h0));

    do_reset();
    run(tbl, 1'b0, "main");
    do_reset();
    run(t3, 1'b0, "branch");
    do_reset();
    run(t4, 1'b0, "jump");
    do_reset();
    run(t5, 1'b0, "redir_gnt");
    do_reset();
    run(t6, 1'b1, "wrap");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
